// File: rtl/fp_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fp_stream_pkg
// Brief   : FSM states, per-read tag and float field indices for fp_stream.
// Rev     : 1.0
// ============================================================================
package fp_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic valid;
        logic start;
        logic last;
    } tag_t;

    localparam int TAG_WIDTH      = $bits(tag_t);
    localparam int FRAC_WIDTH_DEF = 24;
    localparam int EXP_WIDTH_DEF  = 8;

    localparam int SIGN_IDX     = FRAC_WIDTH_DEF + EXP_WIDTH_DEF - 1;
    localparam int EXP_MSB_IDX  = FRAC_WIDTH_DEF + EXP_WIDTH_DEF - 2;
    localparam int EXP_LSB_IDX  = FRAC_WIDTH_DEF - 1;
    localparam int MANT_MSB_IDX = FRAC_WIDTH_DEF - 2;

    // Same field indices for non-default widths.
    function automatic int exp_msb_idx(input int frac_w, input int exp_w);
        return frac_w + exp_w - 2;
    endfunction

    function automatic int exp_lsb_idx(input int frac_w);
        return frac_w - 1;
    endfunction

    function automatic int mant_msb_idx(input int frac_w);
        return frac_w - 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_stream_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module  : fp_stream_tag_pipe
// Brief   : Fixed-depth shift register; async reset clears every stage.
// Rev     : 1.0
// ============================================================================
module fp_stream_tag_pipe
    import fp_stream_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = TAG_WIDTH
) (
    input  logic             clkIn,
    input  logic             rstIn,
    input  logic [WIDTH-1:0] tagIn,
    output logic [WIDTH-1:0] tagOut
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = tagIn;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign tagOut = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/fp_stream_source.sv
`default_nettype none
// ============================================================================
// Module  : fp_stream_source
// Brief   : Turns a (base, len, stride) command into one framed float stream
//           read from a synchronous memory. FP_STREAM_FLUSH_ZERO_EN flushes
//           zero-exponent elements to signed zero.
// Rev     : 1.0
// ============================================================================
module fp_stream_source
    import fp_stream_pkg::*;
#(
    parameter int FRAC_WIDTH   = FRAC_WIDTH_DEF,
    parameter int EXP_WIDTH    = EXP_WIDTH_DEF,
    parameter int ADDR_WIDTH   = 10,
    parameter int LEN_WIDTH    = 10,
    parameter int MEM_LATENCY  = 2,
    localparam int DATA_WIDTH  = FRAC_WIDTH + EXP_WIDTH
) (
    input  logic                  clkIn,
    input  logic                  rstIn,
    input  logic                  cmdValidIn,
    output logic                  cmdReadyOut,
    input  logic [ADDR_WIDTH-1:0] cmdAddrIn,
    input  logic [LEN_WIDTH-1:0]  cmdLenIn,
    input  logic [ADDR_WIDTH-1:0] cmdStrideIn,
    output logic                  memEnOut,
    output logic [ADDR_WIDTH-1:0] memAddrOut,
    input  logic [DATA_WIDTH-1:0] memDataIn,
    output logic                  startOut,
    output logic                  lastOut,
    output logic                  validOut,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  busyOut,
    output logic                  doneOut
);

    state_e                state_q,  state_d;
    logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;
    logic [LEN_WIDTH-1:0]  rem_q,    rem_d;
    tag_t                  issue_tag_q, issue_tag_d;
    tag_t                  pipe_tag;
    logic                  ready_q, ready_d;
    logic                  busy_q,  busy_d;
    logic                  done_q,  done_d;
    logic                  valid_q, valid_d;
    logic                  start_q, start_d;
    logic                  last_q,  last_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  accept;

    assign accept = cmdValidIn & ready_q;

    // rem_q counts the reads still owed after the one currently issued.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        stride_d    = stride_q;
        rem_d       = rem_q;
        issue_tag_d = '0;
        done_d      = pipe_tag.valid & pipe_tag.last;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    stride_d = cmdStrideIn;
                    if (cmdLenIn == '0) begin
                        state_d = ST_DRAIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d           = ST_ISSUE;
                        addr_d            = cmdAddrIn;
                        rem_d             = cmdLenIn - LEN_WIDTH'(1);
                        issue_tag_d.valid = 1'b1;
                        issue_tag_d.start = 1'b1;
                        issue_tag_d.last  = (cmdLenIn == LEN_WIDTH'(1));
                    end
                end
            end
            ST_ISSUE: begin
                if (rem_q == '0) begin
                    state_d = ST_DRAIN;
                end else begin
                    addr_d            = addr_q + stride_q;
                    rem_d             = rem_q - LEN_WIDTH'(1);
                    issue_tag_d.valid = 1'b1;
                    issue_tag_d.last  = (rem_q == LEN_WIDTH'(1));
                end
            end
            ST_DRAIN: begin
                if (done_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    fp_stream_tag_pipe #(
        .DEPTH (MEM_LATENCY),
        .WIDTH (TAG_WIDTH)
    ) u_tag_pipe (
        .clkIn  (clkIn),
        .rstIn  (rstIn),
        .tagIn  (issue_tag_q),
        .tagOut (pipe_tag)
    );

`ifdef FP_STREAM_FLUSH_ZERO_EN
    localparam int EXP_MSB  = exp_msb_idx(FRAC_WIDTH, EXP_WIDTH);
    localparam int EXP_LSB  = exp_lsb_idx(FRAC_WIDTH);
    localparam int MANT_MSB = mant_msb_idx(FRAC_WIDTH);
`endif

    // Denormals become signed zero; sign bit is never touched.
    always_comb begin
        mem_data = memDataIn;
`ifdef FP_STREAM_FLUSH_ZERO_EN
        if (memDataIn[EXP_MSB:EXP_LSB] == '0) begin
            mem_data[MANT_MSB:0] = '0;
        end
`endif
    end

    always_comb begin
        valid_d = pipe_tag.valid;
        start_d = pipe_tag.valid & pipe_tag.start;
        last_d  = pipe_tag.valid & pipe_tag.last;
        data_d  = pipe_tag.valid ? mem_data : '0;
    end

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            stride_q    <= '0;
            rem_q       <= '0;
            issue_tag_q <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
            start_q     <= 1'b0;
            last_q      <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            stride_q    <= stride_d;
            rem_q       <= rem_d;
            issue_tag_q <= issue_tag_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            valid_q     <= valid_d;
            start_q     <= start_d;
            last_q      <= last_d;
            data_q      <= data_d;
        end
    end

    assign cmdReadyOut = ready_q;
    assign memEnOut    = issue_tag_q.valid;
    assign memAddrOut  = addr_q;
    assign busyOut     = busy_q;
    assign doneOut     = done_q;
    assign validOut    = valid_q;
    assign startOut    = start_q;
    assign lastOut     = last_q;
    assign dataOut     = data_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_stream_source.sv
`default_nettype none
// ============================================================================
// Module  : tb_fp_stream_source
// Brief   : Directed bench with a cycle-indexed expectation model for
//           fp_stream_source (honours FP_STREAM_FLUSH_ZERO_EN).
// Rev     : 1.0
// ============================================================================
module tb_fp_stream_source;

    localparam int FW   = 24;
    localparam int EW   = 8;
    localparam int AW   = 10;
    localparam int LW   = 10;
    localparam int L    = 2;
    localparam int DW   = FW + EW;
    localparam int MAXC = 2048;

`ifdef FP_STREAM_FLUSH_ZERO_EN
    localparam logic [31:0] FLUSH_A = 32'h0000_0000;
    localparam logic [31:0] FLUSH_B = 32'h8000_0000;
`else
    localparam logic [31:0] FLUSH_A = 32'h0000_0001;
    localparam logic [31:0] FLUSH_B = 32'h8000_0001;
`endif

    logic          clkIn = 1'b0;
    logic          rstIn = 1'b1;
    logic          cmdValidIn = 1'b0;
    logic          cmdReadyOut;
    logic [AW-1:0] cmdAddrIn = '0;
    logic [LW-1:0] cmdLenIn = '0;
    logic [AW-1:0] cmdStrideIn = '0;
    logic          memEnOut;
    logic [AW-1:0] memAddrOut;
    logic [DW-1:0] memDataIn;
    logic          startOut, lastOut, validOut, busyOut, doneOut;
    logic [DW-1:0] dataOut;

    fp_stream_source #(
        .FRAC_WIDTH  (FW),
        .EXP_WIDTH   (EW),
        .ADDR_WIDTH  (AW),
        .LEN_WIDTH   (LW),
        .MEM_LATENCY (L)
    ) dut (
        .clkIn       (clkIn),
        .rstIn       (rstIn),
        .cmdValidIn  (cmdValidIn),
        .cmdReadyOut (cmdReadyOut),
        .cmdAddrIn   (cmdAddrIn),
        .cmdLenIn    (cmdLenIn),
        .cmdStrideIn (cmdStrideIn),
        .memEnOut    (memEnOut),
        .memAddrOut  (memAddrOut),
        .memDataIn   (memDataIn),
        .startOut    (startOut),
        .lastOut     (lastOut),
        .validOut    (validOut),
        .dataOut     (dataOut),
        .busyOut     (busyOut),
        .doneOut     (doneOut)
    );

    always #5 clkIn = ~clkIn;

    // Synchronous-read memory with L cycles from enable to data.
    logic [31:0] mem  [1024];
    logic [31:0] rd_q [L];
    always @(posedge clkIn) begin
        rd_q[0] <= memEnOut ? mem[memAddrOut] : 32'hDEAD_BEEF;
        for (int i = 1; i < L; i++) rd_q[i] <= rd_q[i-1];
    end
    assign memDataIn = rd_q[L-1];

    // Spec cycle c is the interval that ends at rising edge number c.
    int cyc = 0;
    always @(posedge clkIn) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    bit check_en = 1'b0;
    int cc;

    bit          exp_ready [MAXC];
    bit          exp_busy  [MAXC];
    bit          exp_memen [MAXC];
    int          exp_addr  [MAXC];
    bit          exp_valid [MAXC];
    bit          exp_start [MAXC];
    bit          exp_last  [MAXC];
    bit          exp_done  [MAXC];
    logic [31:0] exp_data  [MAXC];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %08h expected %08h", name, cyc + 1, got, exp);
        end
    endtask

    function automatic logic [31:0] fp_flush(input logic [31:0] d);
`ifdef FP_STREAM_FLUSH_ZERO_EN
        if (((d >> 23) & 32'hFF) == 0) return d & 32'h8000_0000;
`endif
        return d;
    endfunction

    task automatic model_clear(input int from);
        for (int c = from; c < MAXC; c++) begin
            exp_ready[c] = 1'b1; exp_busy[c]  = 1'b0; exp_memen[c] = 1'b0;
            exp_valid[c] = 1'b0; exp_start[c] = 1'b0; exp_last[c]  = 1'b0;
            exp_done[c]  = 1'b0; exp_addr[c]  = 0;    exp_data[c]  = '0;
        end
    endtask

    // Expected behaviour of a command accepted at edge t.
    task automatic plan(input int t, input int base, input int len, input int stride);
        int a;
        int end_c;
        end_c = (len == 0) ? t + 1 : t + 1 + len + L;
        for (int c = t + 1; c <= end_c; c++) begin
            exp_ready[c] = 1'b0;
            exp_busy[c]  = 1'b1;
        end
        exp_done[end_c] = 1'b1;
        for (int k = 0; k < len; k++) begin
            a = (base + k * stride) % 1024;
            exp_memen[t + 1 + k]     = 1'b1;
            exp_addr[t + 1 + k]      = a;
            exp_valid[t + 2 + k + L] = 1'b1;
            exp_data[t + 2 + k + L]  = fp_flush(mem[a]);
            exp_start[t + 2 + k + L] = (k == 0);
            exp_last[t + 2 + k + L]  = (k == len - 1);
        end
    endtask

    always @(negedge clkIn) begin
        if (check_en && (cyc + 1 < MAXC)) begin
            cc = cyc + 1;
            chk("cmdReadyOut", cmdReadyOut, exp_ready[cc]);
            chk("busyOut",     busyOut,     exp_busy[cc]);
            chk("memEnOut",    memEnOut,    exp_memen[cc]);
            if (exp_memen[cc]) chk("memAddrOut", memAddrOut, exp_addr[cc]);
            chk("validOut",    validOut,    exp_valid[cc]);
            chk("startOut",    startOut,    exp_start[cc]);
            chk("lastOut",     lastOut,     exp_last[cc]);
            chk("doneOut",     doneOut,     exp_done[cc]);
            if (exp_valid[cc]) chk("dataOut", dataOut, exp_data[cc]);
        end
    end

    task automatic wait_cycle(input int c);
        do @(negedge clkIn); while (cyc + 1 < c);
    endtask

    task automatic send(input int base, input int len, input int stride, output int t);
        int tries;
        tries = 0;
        do begin
            @(negedge clkIn);
            tries++;
        end while (!exp_ready[cyc + 1] && tries < 200);
        t = cyc + 1;
        if (!exp_ready[cyc + 1]) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout cycle %0d: model never idle", cyc + 1);
            return;
        end
        cmdValidIn  = 1'b1;
        cmdAddrIn   = AW'(base);
        cmdLenIn    = LW'(len);
        cmdStrideIn = AW'(stride);
        plan(t, base, len, stride);
        @(posedge clkIn);
        #1 cmdValidIn = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clkIn);
        #2 check_en = 1'b0;
        rstIn = 1'b0;
        #1;
        chk("rst_cmdReadyOut", cmdReadyOut, 0);
        chk("rst_memEnOut",    memEnOut,    0);
        chk("rst_memAddrOut",  memAddrOut,  0);
        chk("rst_validOut",    validOut,    0);
        chk("rst_startOut",    startOut,    0);
        chk("rst_lastOut",     lastOut,     0);
        chk("rst_dataOut",     dataOut,     0);
        chk("rst_busyOut",     busyOut,     0);
        chk("rst_doneOut",     doneOut,     0);
        repeat (2) @(negedge clkIn);
        #2 rstIn = 1'b1;
        #1;
        chk("rel_cmdReadyOut", cmdReadyOut, 0);
        chk("rel_validOut",    validOut,    0);
        model_clear(cyc + 1);
        exp_ready[cyc + 1] = 1'b0;
        check_en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h4000_0000 | i;
        mem[10'h010] = 32'h3F80_0000;
        mem[10'h011] = 32'h4000_0000;
        mem[10'h012] = 32'h4040_0000;
        mem[10'h013] = 32'h4080_0000;
        mem[10'h020] = 32'hC000_0000;
        mem[10'h030] = 32'h0000_0001;
        mem[10'h031] = 32'h8000_0001;
        model_clear(0);

        apply_reset();

        // len=4 frame with a command attempt mid-frame that must be ignored.
        send(10'h010, 4, 1, t);
        wait_cycle(t + 1);
        chk("t1_memEn_first", memEnOut, 1);
        chk("t1_addr_first",  memAddrOut, 10'h010);
        wait_cycle(t + 2);
        cmdValidIn = 1'b1; cmdAddrIn = 10'h050; cmdLenIn = 5;
        @(posedge clkIn);
        #1 cmdValidIn = 1'b0;
        wait_cycle(t + 4);
        chk("t1_start",      startOut, 1);
        chk("t1_data0",      dataOut,  32'h3F80_0000);
        wait_cycle(t + 7);
        chk("t1_last",       lastOut,  1);
        chk("t1_done",       doneOut,  1);
        chk("t1_data3",      dataOut,  32'h4080_0000);
        wait_cycle(t + 8);
        chk("t1_ready_back", cmdReadyOut, 1);

        // len=1: start and last on the same element.
        send(10'h020, 1, 1, t);
        wait_cycle(t + 4);
        chk("t2_valid", validOut, 1);
        chk("t2_start", startOut, 1);
        chk("t2_last",  lastOut,  1);
        chk("t2_data",  dataOut,  32'hC000_0000);

        // len=0: done the cycle after accept, no reads.
        send(10'h040, 0, 1, t);
        wait_cycle(t + 1);
        chk("t3_done",  doneOut,  1);
        chk("t3_memEn", memEnOut, 0);
        wait_cycle(t + 2);
        chk("t3_ready", cmdReadyOut, 1);

        // Address wrap modulo 2^10.
        send(10'h3FE, 3, 3, t);
        wait_cycle(t + 1);
        chk("t4_addr0", memAddrOut, 10'h3FE);
        wait_cycle(t + 2);
        chk("t4_addr1", memAddrOut, 10'h001);
        wait_cycle(t + 3);
        chk("t4_addr2", memAddrOut, 10'h004);

        // Reset mid-frame, then a fresh command.
        send(10'h100, 8, 1, t);
        wait_cycle(t + 5);
        apply_reset();
        send(10'h200, 2, 1, t);
        wait_cycle(t + 4);
        chk("t5_data0", dataOut, 32'h4000_0200);
        wait_cycle(t + 5);
        chk("t5_last",  lastOut, 1);

        // Zero-exponent elements.
        send(10'h030, 2, 1, t);
        wait_cycle(t + 4);
        chk("t6_flush_pos", dataOut, FLUSH_A);
        wait_cycle(t + 5);
        chk("t6_flush_neg", dataOut, FLUSH_B);

        wait_cycle(t + 10);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_stream_source.md
# fp_stream_source

Command-driven stream generator that fetches a floating-point vector from a synchronous-read memory and emits it as a framed stream on `startOut`/`lastOut`/`validOut`/`dataOut`. This is exactly the framing the floating-point accumulator consumes. It sits upstream of the accumulator in the accelerator datapath and turns a (base, length, stride) command into one accumulation frame. It does not support backpressure, because the accumulator accepts one element per cycle unconditionally.

## Interface
- `FRAC_WIDTH`, 24: fraction width including hidden/sign convention of the codebase; `DATA_WIDTH = FRAC_WIDTH + EXP_WIDTH`.
- `EXP_WIDTH`, 8: exponent width.
- `ADDR_WIDTH`, 10: memory address width.
- `LEN_WIDTH`, 10: command length width.
- `MEM_LATENCY`, 2: cycles from `memEnOut` to valid `memDataIn`; must be at least 1.

Ports:
- `clkIn` in 1: clock.
- `rstIn` in 1: reset, asynchronous, active-low.
- `cmdValidIn` in 1: command valid.
- `cmdReadyOut` out 1: command accepted when `cmdValidIn & cmdReadyOut` at a rising edge.
- `cmdAddrIn` in `ADDR_WIDTH`: base address.
- `cmdLenIn` in `LEN_WIDTH`: element count (0 allowed).
- `cmdStrideIn` in `ADDR_WIDTH`: address increment per element.
- `memEnOut` out 1: read enable.
- `memAddrOut` out `ADDR_WIDTH`: read address.
- `memDataIn` in `DATA_WIDTH`: read data.
- `startOut` out 1: first element of frame.
- `lastOut` out 1: final element of frame.
- `validOut` out 1: element valid.
- `dataOut` out `DATA_WIDTH`: element.
- `busyOut` out 1: command in progress.
- `doneOut` out 1: one-cycle pulse at frame completion.

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE: `cmdReadyOut`=1. On accept, latch base, length and stride.
    - len>0 → ISSUE.
    - len=0 → DRAIN with no reads.
  - ISSUE: one read per cycle. Element k reads `base + k*stride` (running adder, modulo 2^ADDR_WIDTH wrap). After element len-1 → DRAIN.
  - DRAIN: wait until the final tagged element leaves the output register, then → IDLE.
- Tag pipeline carries {valid, start, last} for each read, `MEM_LATENCY` stages deep, aligned with `memDataIn`.
  - start=1 for k=0; last=1 for k=len-1.
  - len=1: start and last are both set on the same element.
- Output register captures `memDataIn` and the tags. `startOut`/`lastOut` are qualified by `validOut`; they are 0 when `validOut`=0.
- `busyOut`=1 in ISSUE and DRAIN.
- `doneOut` fires in the same cycle as the `validOut & lastOut` output. For len=0 it fires the cycle after accept.
- `cmdValidIn` outside IDLE is ignored, not queued.
- Reset (any time, including mid-frame):
  - State → IDLE.
  - Tag pipeline cleared, so no stray `validOut` after release.
  - All outputs 0, including `cmdReadyOut`, `dataOut`, `memAddrOut`.
  - `cmdReadyOut` rises at the first edge after release.

## Timing
- Accept at edge T. Element k:
  - `memEnOut` high in cycle T+1+k.
  - `memDataIn` valid in cycle T+1+k+MEM_LATENCY.
  - `validOut` high in cycle T+2+k+MEM_LATENCY.
- Frame elements are contiguous: `validOut` has no gaps within a frame.
- `doneOut` is high in cycle T+1+len+MEM_LATENCY. `cmdReadyOut` returns high the following cycle.
  - Minimum spacing between accepts is len+MEM_LATENCY+2 cycles (len≥1).
- len=0: `doneOut` in cycle T+1, ready in cycle T+2.
- `memEnOut`, `memAddrOut`, `cmdReadyOut`, `busyOut` and all stream outputs are registered.

## Configuration
- `FP_STREAM_FLUSH_ZERO_EN` defined: an element whose exponent field, bits `[DATA_WIDTH-2:FRAC_WIDTH-1]`, is all zero has its mantissa, bits `[FRAC_WIDTH-2:0]`, cleared before the output register. The sign is preserved, so denormals become signed zero. Latency is unchanged.
- `FP_STREAM_FLUSH_ZERO_EN` not defined: data passes through unmodified.

## Structure
- Package `fp_stream_pkg`:
  - FSM state enum.
  - Tag struct {valid, start, last}.
  - Field-index localparams for sign, exponent and mantissa, derived from `FRAC_WIDTH`/`EXP_WIDTH`.
- Sub-module `fp_stream_tag_pipe`: a parameterized-depth shift register, async active-low reset clearing all stages, used for the tag pipeline.

## Test plan
- len=4, base 0x010, stride 1, mem[0x010..0x013]=0x3F800000, 0x40000000, 0x40400000, 0x40800000, MEM_LATENCY=2, accept at T → reads at 0x010..0x013 in cycles T+1..T+4; `validOut` in cycles T+4..T+7 with data in that order; `startOut` at T+4; `lastOut` and `doneOut` at T+7; `cmdReadyOut` high at T+8.
- len=1, mem=0xC0000000 → single `validOut` with `startOut`=`lastOut`=1, data 0xC0000000.
- len=0 → no `memEnOut`, no `validOut`; `doneOut` pulse at T+1; ready at T+2.
- base 0x3FE, stride 3, len 3, ADDR_WIDTH=10 → addresses 0x3FE, 0x001, 0x004.
- len=8, reset asserted after 2 outputs → all outputs 0 within the reset cycle; after release no `validOut` appears; `cmdReadyOut`=1 one edge later; a new len=2 command produces a correct frame.
- mem data 0x00000001 and 0x80000001 → with `FP_STREAM_FLUSH_ZERO_EN` outputs are 0x00000000 and 0x80000000; without it the data is unchanged.
